mod_w_wnd_comp: RTL and testbench

SHA-256 compression core with an on-chip 16-word message-schedule (W) window. It sits between external H, message and K storage, driven by an 8-bit command from the hashing sequencer. It loads working registers a..h from H storage and runs the 64 compression rounds, fetching M words and K constants by address. It then writes back H+a..h either to H storage or to message storage, the latter for double-SHA chaining. Each command finishes with a RDY level that stays high until the sequencer returns CMD to idle.

---
 rtl/mod_w_wnd_comp_if.sv | 22 ++
 rtl/mod_w_wnd_comp.sv | 196 +++++++++++++++++++
 tb/tb_mod_w_wnd_comp.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_w_wnd_comp_if.sv
// Bus bundle for mod_w_wnd_comp.
//   CMD     sequencer command code (IDLE/LOAD_H/HASH/SUM_STORE_H/SUM_STORE_M)
//   MKA     message/K address (round index during HASH)
//   MD_IN   message word for MKA, KD K constant for MKA (both combinational)
//   HA      H storage address, HD_IN H word for HA (combinational)
//   HD_OUT  sum word toward H storage, MD_OUT same sum toward message storage
//   RDY     command complete level
// slave: the compression core; master: sequencer plus external storage.
interface mod_w_wnd_comp_if;
  logic [7:0]  CMD;
  logic [7:0]  MKA;
  logic [31:0] MD_IN;
  logic [31:0] MD_OUT;
  logic [31:0] KD;
  logic [7:0]  HA;
  logic [31:0] HD_IN;
  logic [31:0] HD_OUT;
  logic        RDY;

  modport slave  (input CMD, MD_IN, KD, HD_IN, output MKA, MD_OUT, HA, HD_OUT, RDY);
  modport master (output CMD, MD_IN, KD, HD_IN, input MKA, MD_OUT, HA, HD_OUT, RDY);
endinterface

// File: rtl/mod_w_wnd_comp.sv
// SHA-256 compression core with a 16-word on-chip message-schedule window.
// Loads a..h from H storage, runs 64 rounds fetching M/K by round index, and
// presents H+a..h for write-back to either H or message storage.
// Ports:
//   CLK  clock, all state changes on posedge
//   RST  synchronous active-high reset
//   bus  mod_w_wnd_comp_if.slave (CMD, MKA, MD_IN, MD_OUT, KD, HA, HD_IN, HD_OUT, RDY)
// Optional macro MOD_W_WND_COMP_CHECK_EN adds simulation-only protocol/X checks.
module mod_w_wnd_comp (
  input logic             CLK,
  input logic             RST,
  mod_w_wnd_comp_if.slave bus
);
  localparam logic [7:0] CMD_IDLE        = 8'd0;
  localparam logic [7:0] CMD_LOAD_H      = 8'd1;
  localparam logic [7:0] CMD_HASH        = 8'd2;
  localparam logic [7:0] CMD_SUM_STORE_H = 8'd3;
  localparam logic [7:0] CMD_SUM_STORE_M = 8'd4;

  typedef enum logic [2:0] {IDLE, LOAD, HASH, SUM, DONE} state_t;

  state_t            state, state_n;
  logic [5:0]        cnt;
  logic [5:0]        cnt_inc;
  logic [7:0]        ha_q, mka_q;
  logic [31:0]       a, b, c, d, e, f, g, h;
  // wnd[15] = W[t-1] ... wnd[0] = W[t-16]
  logic [15:0][31:0] wnd;
  logic [31:0]       w_t, t1, t2, sel_reg;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign cnt_inc = cnt + 6'd1;

  // Rounds 0..15 take the message word directly; later ones expand from the window.
  assign w_t = (cnt < 6'd16) ? bus.MD_IN
                             : ssig1(wnd[14]) + wnd[9] + ssig0(wnd[1]) + wnd[0];
  assign t1  = h + bsig1(e) + ((e & f) ^ (~e & g)) + bus.KD + w_t;
  assign t2  = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));

  always_comb begin
    sel_reg = a;
    case (ha_q[2:0])
      3'd0: sel_reg = a;
      3'd1: sel_reg = b;
      3'd2: sel_reg = c;
      3'd3: sel_reg = d;
      3'd4: sel_reg = e;
      3'd5: sel_reg = f;
      3'd6: sel_reg = g;
      3'd7: sel_reg = h;
      default: sel_reg = a;
    endcase
  end

  // The sum is always driven; the external store only samples it during SUM.
  assign bus.HD_OUT = bus.HD_IN + sel_reg;
  assign bus.MD_OUT = bus.HD_IN + sel_reg;
  assign bus.HA     = ha_q;
  assign bus.MKA    = mka_q;
  assign bus.RDY    = (state == DONE);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        case (bus.CMD)
          CMD_LOAD_H:                       state_n = LOAD;
          CMD_HASH:                         state_n = HASH;
          CMD_SUM_STORE_H, CMD_SUM_STORE_M: state_n = SUM;
          default:                          state_n = IDLE;
        endcase
      end
      LOAD:    if (cnt == 6'd7)  state_n = DONE;
      HASH:    if (cnt == 6'd63) state_n = DONE;
      SUM:     if (cnt == 6'd7)  state_n = DONE;
      DONE:    if (bus.CMD == CMD_IDLE) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt   <= '0;
      ha_q  <= '0;
      mka_q <= '0;
      {a, b, c, d, e, f, g, h} <= '0;
      wnd   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (state_n != IDLE) begin
            cnt   <= '0;
            ha_q  <= '0;
            mka_q <= '0;
          end
        end
        LOAD: begin
          case (cnt[2:0])
            3'd0: a <= bus.HD_IN;
            3'd1: b <= bus.HD_IN;
            3'd2: c <= bus.HD_IN;
            3'd3: d <= bus.HD_IN;
            3'd4: e <= bus.HD_IN;
            3'd5: f <= bus.HD_IN;
            3'd6: g <= bus.HD_IN;
            3'd7: h <= bus.HD_IN;
            default: ;
          endcase
          if (cnt != 6'd7) begin
            cnt  <= cnt_inc;
            ha_q <= {2'b00, cnt_inc};
          end
        end
        HASH: begin
          h   <= g;
          g   <= f;
          f   <= e;
          e   <= d + t1;
          d   <= c;
          c   <= b;
          b   <= a;
          a   <= t1 + t2;
          wnd <= {w_t, wnd[15:1]};
          if (cnt != 6'd63) begin
            cnt   <= cnt_inc;
            mka_q <= {2'b00, cnt_inc};
          end
        end
        SUM: begin
          if (cnt != 6'd7) begin
            cnt  <= cnt_inc;
            ha_q <= {2'b00, cnt_inc};
          end
        end
        DONE: begin
          // Addresses hold through DONE; MKA drops back to 0 once idle.
          if (state_n == IDLE) mka_q <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef MOD_W_WND_COMP_CHECK_EN
  // The latched command only matters for detecting mid-command changes.
  logic [7:0] cmd_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cmd_q <= CMD_IDLE;
    end else begin
      if ($isunknown(bus.CMD))
        $error("mod_w_wnd_comp: CMD is X/Z");
      if (state == IDLE) begin
        if (!$isunknown(bus.CMD) && bus.CMD > CMD_SUM_STORE_M)
          $error("mod_w_wnd_comp: unknown command %0h", bus.CMD);
        if (state_n != IDLE) cmd_q <= bus.CMD;
      end
      if ((state == LOAD || state == HASH || state == SUM) &&
          bus.CMD != CMD_IDLE && bus.CMD != cmd_q)
        $error("mod_w_wnd_comp: command changed while busy (%0h -> %0h)", cmd_q, bus.CMD);
      if ((state == LOAD || state == SUM) && $isunknown(bus.HD_IN))
        $error("mod_w_wnd_comp: HD_IN is X/Z");
      if (state == HASH && ($isunknown(bus.MD_IN) || $isunknown(bus.KD)))
        $error("mod_w_wnd_comp: MD_IN/KD is X/Z");
    end
  end
`else
  // Checks compiled out; datapath and FSM are unaffected.
`endif

endmodule

// File: tb/tb_mod_w_wnd_comp.sv
// Self-checking bench for mod_w_wnd_comp: Bitcoin genesis vector table,
// randomized blocks against a full-schedule SHA-256 model, reset mid-HASH.
module tb_mod_w_wnd_comp;
  localparam logic [7:0] C_IDLE = 8'd0;
  localparam logic [7:0] C_LOAD = 8'd1;
  localparam logic [7:0] C_HASH = 8'd2;
  localparam logic [7:0] C_SUMH = 8'd3;
  localparam logic [7:0] C_SUMM = 8'd4;

  logic CLK, RST;
  mod_w_wnd_comp_if bus();

  mod_w_wnd_comp dut (.CLK(CLK), .RST(RST), .bus(bus));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  logic [31:0] hmem [8];
  logic [31:0] mmem [16];
  logic [31:0] kmem [64];
  logic [31:0] blk0 [16];
  logic [31:0] blk1 [16];
  logic [31:0] iv   [8];
  logic [31:0] mdl  [8];
  logic [31:0] cap_h [8];
  logic [31:0] cap_m [8];
  logic [31:0] exp_s [8];
  int pass_cnt = 0;
  int total_cnt = 0;

  // External storage: combinational reads addressed by the DUT.
  always_comb begin
    bus.HD_IN = hmem[bus.HA[2:0]];
    bus.MD_IN = mmem[bus.MKA[3:0]];
    bus.KD    = kmem[bus.MKA[5:0]];
  end

  typedef struct {
    string       nm;
    logic [7:0]  cmd;
    int          blk;   // message block presented during the step
    int          sel;   // 0: a..h, 1: HD_OUT writes, 2: MD_OUT writes
    logic [7:0]  mask;
    logic [31:0] exp [8];
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %h, want %h", nm, act, expv);
  endtask

  function automatic logic [31:0] dreg(input int i);
    case (i)
      0: return dut.a;
      1: return dut.b;
      2: return dut.c;
      3: return dut.d;
      4: return dut.e;
      5: return dut.f;
      6: return dut.g;
      default: return dut.h;
    endcase
  endfunction

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference compression: full 64-word schedule, working vars v[0]=a..v[7]=h.
  task automatic model_hash();
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = mmem[t];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    v = mdl;
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kmem[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    mdl = v;
  endtask

  task automatic chk_regs(input string nm);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_r%0d", nm, i), dreg(i), mdl[i]);
  endtask

  // Issue one command, track address sequence and RDY latency, return to idle.
  task automatic do_cmd(input logic [7:0] cm, input string nm);
    int nc, aerr, rerr;
    nc = (cm == C_HASH) ? 64 : 8;
    aerr = 0;
    rerr = 0;
    @(negedge CLK);
    bus.CMD = cm;
    @(posedge CLK);
    for (int i = 0; i < nc; i++) begin
      @(negedge CLK);
      if (bus.RDY !== 1'b0) rerr++;
      if (cm == C_HASH) begin
        if (bus.MKA !== 8'(i)) aerr++;
      end else if (bus.HA !== 8'(i)) aerr++;
      if (i < 8) begin
        cap_h[i] = bus.HD_OUT;
        cap_m[i] = bus.MD_OUT;
      end
    end
    @(negedge CLK);
    chk({nm, "_rdy_latency"}, 32'(bus.RDY), 32'd1);
    chk({nm, "_busy_rdy_low"}, rerr, 0);
    chk({nm, "_addr_seq"}, aerr, 0);
    if (cm == C_HASH) chk({nm, "_mka_hold"}, 32'(bus.MKA), 32'd63);
    else              chk({nm, "_ha_hold"}, 32'(bus.HA), 32'd7);
    bus.CMD = C_IDLE;
    @(negedge CLK);
    chk({nm, "_rdy_fall"}, 32'(bus.RDY), 32'd0);
  endtask

  initial begin
    kmem = '{32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
             32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
             32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
             32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
             32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
             32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
             32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
             32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    iv   = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    blk0 = '{32'h01000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
             32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61, 32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa};
    blk1 = '{32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c, 32'h80000000, 32'h0, 32'h0, 32'h0,
             32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000280};

    tbl[0].nm = "load_iv";  tbl[0].cmd = C_LOAD; tbl[0].blk = 0; tbl[0].sel = 0; tbl[0].mask = 8'hff;
    tbl[0].exp = iv;
    tbl[1].nm = "hash_b0";  tbl[1].cmd = C_HASH; tbl[1].blk = 0; tbl[1].sel = 0; tbl[1].mask = 8'hff;
    tbl[1].exp = '{32'h5286b3cc, 32'ha7f1116b, 32'h545db90b, 32'h7909d56e, 32'h72ba866a, 32'hb3fb9b3c, 32'h772dad8b, 32'heb392c02};
    tbl[2].nm = "store_h";  tbl[2].cmd = C_SUMH; tbl[2].blk = 0; tbl[2].sel = 1; tbl[2].mask = 8'hff;
    tbl[2].exp = '{32'hbc909a33, 32'h6358bff0, 32'h90ccac7d, 32'h1e59caa8, 32'hc3c8d8e9, 32'h4f0103c8, 32'h96b18736, 32'h4719f91b};
    tbl[3].nm = "load_mid"; tbl[3].cmd = C_LOAD; tbl[3].blk = 1; tbl[3].sel = 0; tbl[3].mask = 8'hff;
    tbl[3].exp = tbl[2].exp;
    tbl[4].nm = "hash_b1";  tbl[4].cmd = C_HASH; tbl[4].blk = 1; tbl[4].sel = 0; tbl[4].mask = 8'h81;
    tbl[4].exp = '{32'hf2b168eb, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h2aabdd52};
    tbl[5].nm = "store_m";  tbl[5].cmd = C_SUMM; tbl[5].blk = 1; tbl[5].sel = 2; tbl[5].mask = 8'hff;
    tbl[5].exp = '{32'haf42031e, 32'h805ff493, 32'ha07341e2, 32'hf74ff581, 32'h49d22ab9, 32'hba19f613, 32'h43e2c86c, 32'h71c5d66d};

    hmem = iv;
    mmem = blk0;
    bus.CMD = C_IDLE;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_rdy", 32'(bus.RDY), 32'd0);
    chk("rst_ha", 32'(bus.HA), 32'd0);
    chk("rst_mka", 32'(bus.MKA), 32'd0);
    chk("rst_hd_out", bus.HD_OUT, iv[0]);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_r%0d", i), dreg(i), 32'd0);
    for (int i = 0; i < 8; i++) mdl[i] = 32'd0;

    // Genesis-header vector table.
    for (int s = 0; s < 6; s++) begin
      mmem = (tbl[s].blk == 0) ? blk0 : blk1;
      do_cmd(tbl[s].cmd, tbl[s].nm);
      if (tbl[s].cmd == C_LOAD) mdl = hmem;
      else if (tbl[s].cmd == C_HASH) model_hash();
      for (int i = 0; i < 8; i++) exp_s[i] = hmem[i] + mdl[i];
      for (int i = 0; i < 8; i++) begin
        if (tbl[s].mask[i]) begin
          case (tbl[s].sel)
            0:       chk($sformatf("%s_r%0d", tbl[s].nm, i), dreg(i), tbl[s].exp[i]);
            1:       chk($sformatf("%s_hd%0d", tbl[s].nm, i), cap_h[i], tbl[s].exp[i]);
            default: chk($sformatf("%s_md%0d", tbl[s].nm, i), cap_m[i], tbl[s].exp[i]);
          endcase
        end
      end
      if (tbl[s].sel == 0) chk_regs({tbl[s].nm, "_mdl"});
      else for (int i = 0; i < 8; i++)
        chk($sformatf("%s_mdl%0d", tbl[s].nm, i), (tbl[s].sel == 1) ? cap_h[i] : cap_m[i], exp_s[i]);
      if (tbl[s].cmd == C_SUMH) hmem = cap_h;
    end

    // Randomized blocks against the reference model.
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 8; i++) hmem[i] = $urandom;
      for (int i = 0; i < 16; i++) mmem[i] = $urandom;
      if ($urandom_range(0, 1) == 1 || it == 0) begin
        do_cmd(C_LOAD, "rnd_load");
        mdl = hmem;
        chk_regs($sformatf("rnd%0d_load", it));
      end
      do_cmd(C_HASH, "rnd_hash");
      model_hash();
      chk_regs($sformatf("rnd%0d_hash", it));
      for (int i = 0; i < 8; i++) hmem[i] = $urandom;
      for (int i = 0; i < 8; i++) exp_s[i] = hmem[i] + mdl[i];
      if ($urandom_range(0, 1) == 1) begin
        do_cmd(C_SUMH, "rnd_sumh");
        for (int i = 0; i < 8; i++) chk($sformatf("rnd%0d_hd%0d", it, i), cap_h[i], exp_s[i]);
      end else begin
        do_cmd(C_SUMM, "rnd_summ");
        for (int i = 0; i < 8; i++) chk($sformatf("rnd%0d_md%0d", it, i), cap_m[i], exp_s[i]);
      end
      chk_regs($sformatf("rnd%0d_sum_keep", it));
`ifndef MOD_W_WND_COMP_CHECK_EN
      @(negedge CLK);
      bus.CMD = 8'($urandom_range(5, 255));
      repeat (10) @(negedge CLK);
      chk($sformatf("rnd%0d_bad_cmd_rdy", it), 32'(bus.RDY), 32'd0);
      chk($sformatf("rnd%0d_bad_cmd_ha", it), 32'(bus.HA), 32'd7);
      bus.CMD = C_IDLE;
      @(negedge CLK);
      chk_regs($sformatf("rnd%0d_bad_cmd_keep", it));
`endif
    end

    // Reset during round 30 of a HASH, then recover with LOAD_H.
    hmem = iv;
    mmem = blk0;
    do_cmd(C_LOAD, "pre_rst_load");
    @(negedge CLK);
    bus.CMD = C_HASH;
    @(posedge CLK);
    for (int i = 0; i <= 30; i++) @(negedge CLK);
    chk("mid_hash_mka", 32'(bus.MKA), 32'd30);
    RST = 1'b1;
    bus.CMD = C_IDLE;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_rdy", 32'(bus.RDY), 32'd0);
    chk("abort_mka", 32'(bus.MKA), 32'd0);
    chk("abort_ha", 32'(bus.HA), 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("abort_r%0d", i), dreg(i), 32'd0);
    do_cmd(C_LOAD, "post_rst_load");
    mdl = iv;
    chk_regs("post_rst_load");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
